// File: rtl/sound_seq_if.sv
// sound_seq_if: bundle between the game logic and the tone sequencer.
//   trig       : level requests, one per effect (rising edge starts it)
//   mute       : forces the buzzer low while sequencing continues
//   buzzer     : square-wave output to the buzzer pin
//   busy       : an effect is playing
//   cur_effect : index of the playing effect (0 when idle)
//   step_idx   : current step within the effect (0 when idle)
// master = game logic side, slave = sequencer side.
interface sound_seq_if #(
    parameter int N_TRIG = 3
);
    logic [N_TRIG-1:0] trig;
    logic              mute;
    logic              buzzer;
    logic              busy;
    logic [2:0]        cur_effect;
    logic [3:0]        step_idx;

    modport master (
        output trig, mute,
        input  buzzer, busy, cur_effect, step_idx
    );

    modport slave (
        input  trig, mute,
        output buzzer, busy, cur_effect, step_idx
    );
endinterface

// File: rtl/sound_seq.sv
// sound_seq: multi-effect tone sequencer driving a buzzer pin.
// Each trigger input starts a stored effect: a list of steps, each a square
// tone or a silent gap lasting hp*dur clocks. Higher trigger index has
// priority; an equal index restarts the effect, a lower one is dropped.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : sound_seq_if slave (trig, mute in; buzzer, busy, cur_effect,
//         step_idx out)
//
// state  | meaning
// S_IDLE | no effect playing, outputs parked at 0
// S_PLAY | stepping through effect cur_effect, step step_idx
module sound_seq #(
    parameter int N_TRIG = 3,
    parameter int STEPS  = 4,
    parameter int HP_W   = 20,
    parameter int DUR_W  = 10,
    parameter logic [N_TRIG*STEPS*(1+HP_W+DUR_W)-1:0] TABLE = '0
) (
    input  logic      clk,
    input  logic      rst,
    sound_seq_if.slave bus
);
    localparam int EW = 1 + HP_W + DUR_W;
    localparam int NE = N_TRIG * STEPS;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    logic [HP_W-1:0]  hp_tab  [NE];
    logic [DUR_W-1:0] dur_tab [NE];
    logic             sil_tab [NE];

    for (genvar i = 0; i < NE; i++) begin : g_tab
        assign dur_tab[i] = TABLE[i*EW +: DUR_W];
        assign hp_tab[i]  = TABLE[i*EW + DUR_W +: HP_W];
        assign sil_tab[i] = TABLE[i*EW + DUR_W + HP_W];
    end

    logic [0:0]        state;
    logic [2:0]        cur;
    logic [3:0]        step;
    logic [HP_W-1:0]   cnt;
    logic [DUR_W-1:0]  waves;
    logic              tone;
    logic              buzzer_r;
    logic [N_TRIG-1:0] trig_q;
    logic              armed;

    logic [N_TRIG-1:0] rise;
    logic              any_rise;
    logic [2:0]        cand;
    logic              start;
    logic [IW-1:0]     cur_i;
    logic [IW-1:0]     nxt_i;
    logic [IW-1:0]     cand_i;
    logic [HP_W-1:0]   hp_m1;
    logic              last_step;
    logic              busy;

    assign busy = (state == S_PLAY);

    // armed masks the first cycle after reset so a trigger held through
    // reset is not mistaken for a fresh edge.
    assign rise = bus.trig & ~trig_q & {N_TRIG{armed}};

    always_comb begin
        any_rise = 1'b0;
        cand     = '0;
        for (int i = 0; i < N_TRIG; i++) begin
            if (rise[i]) begin
                any_rise = 1'b1;
                cand     = 3'(i);
            end
        end
    end

    always_comb begin
        cur_i  = IW'(int'(cur) * STEPS + int'(step));
        nxt_i  = (step == 4'(STEPS - 1)) ? cur_i : cur_i + IW'(1);
        cand_i = IW'(int'(cand) * STEPS);
        hp_m1  = (hp_tab[cur_i] == '0) ? '0 : hp_tab[cur_i] - HP_W'(1);
        last_step = (step == 4'(STEPS - 1)) || (dur_tab[nxt_i] == '0);
        // An effect whose first step has zero duration is treated as empty.
        start = any_rise && (dur_tab[cand_i] != '0) && (!busy || cand >= cur);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cur      <= '0;
            step     <= '0;
            cnt      <= '0;
            waves    <= '0;
            tone     <= 1'b0;
            buzzer_r <= 1'b0;
            trig_q   <= '0;
            armed    <= 1'b0;
        end else begin
            trig_q   <= bus.trig;
            armed    <= 1'b1;
            buzzer_r <= busy & ~sil_tab[cur_i] & tone & ~bus.mute;
            if (start) begin
                state <= S_PLAY;
                cur   <= cand;
                step  <= '0;
                cnt   <= '0;
                waves <= '0;
                tone  <= 1'b0;
            end else if (busy) begin
                if (cnt == hp_m1) begin
                    cnt <= '0;
                    if (waves + DUR_W'(1) == dur_tab[cur_i]) begin
                        waves <= '0;
                        tone  <= 1'b0;
                        if (last_step) begin
                            state <= S_IDLE;
                            cur   <= '0;
                            step  <= '0;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end else begin
                        tone  <= ~tone;
                        waves <= waves + DUR_W'(1);
                    end
                end else begin
                    cnt <= cnt + HP_W'(1);
                end
            end
        end
    end

    assign bus.buzzer     = buzzer_r;
    assign bus.busy       = busy;
    assign bus.cur_effect = cur;
    assign bus.step_idx   = step;
endmodule

// File: tb/tb_sound_seq.sv
// tb_sound_seq: self-checking bench for sound_seq (3 effects, 3 steps).
// A behavioural model tracks only (effect, age since start); step, tone and
// silence are derived arithmetically from the step table.
module tb_sound_seq;
    localparam int N  = 3;
    localparam int ST = 3;

    // Entries listed from index 8 down to 0, each {silent, hp, dur}.
    localparam logic [N*ST*31-1:0] TBL = {
        {1'b0, 20'd0, 10'd0}, {1'b0, 20'd0, 10'd0}, {1'b0, 20'd3, 10'd6},
        {1'b0, 20'd5, 10'd2}, {1'b1, 20'd3, 10'd2}, {1'b0, 20'd2, 10'd4},
        {1'b0, 20'd0, 10'd0}, {1'b0, 20'd0, 10'd0}, {1'b0, 20'd4, 10'd2}
    };

    int m_hp  [N][ST] = '{'{4, 0, 0}, '{2, 3, 5}, '{3, 0, 0}};
    int m_dur [N][ST] = '{'{2, 0, 0}, '{4, 2, 2}, '{6, 0, 0}};
    int m_sil [N][ST] = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 0, 0}};

    logic clk = 1'b0;
    logic rst;
    logic chk_en;
    int   checks   = 0;
    int   failures = 0;

    sound_seq_if #(.N_TRIG(N)) bus ();

    sound_seq #(
        .N_TRIG(N), .STEPS(ST), .HP_W(20), .DUR_W(10), .TABLE(TBL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void locate(input int e, input int age,
                                   output int s, output int tone, output int sil);
        int a;
        a = age; s = 0; tone = 0; sil = 0;
        for (int j = 0; j < ST; j++) begin
            int h;
            int len;
            if (m_dur[e][j] == 0) break;
            h   = (m_hp[e][j] == 0) ? 1 : m_hp[e][j];
            len = h * m_dur[e][j];
            if (a < len) begin
                s = j; tone = (a / h) % 2; sil = m_sil[e][j];
                return;
            end
            a -= len;
        end
    endfunction

    function automatic int total_len(input int e);
        int t;
        t = 0;
        for (int j = 0; j < ST; j++) begin
            if (m_dur[e][j] == 0) break;
            t += ((m_hp[e][j] == 0) ? 1 : m_hp[e][j]) * m_dur[e][j];
        end
        return t;
    endfunction

    // Reference model
    logic [N-1:0] m_prev;
    logic         m_armed;
    logic         m_busy;
    int           m_eff;
    int           m_age;
    logic         m_buz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev <= '0; m_armed <= 1'b0; m_busy <= 1'b0;
            m_eff <= 0; m_age <= 0; m_buz <= 1'b0;
        end else begin
            int s, t, sl, k;
            logic [N-1:0] ed;
            locate(m_eff, m_age, s, t, sl);
            m_buz <= m_busy && (sl == 0) && (t == 1) && !bus.mute;
            ed = m_armed ? (bus.trig & ~m_prev) : '0;
            k = -1;
            for (int i = 0; i < N; i++) if (ed[i]) k = i;
            if (k >= 0 && m_dur[k][0] != 0 && (!m_busy || k >= m_eff)) begin
                m_busy <= 1'b1; m_eff <= k; m_age <= 0;
            end else if (m_busy) begin
                if (m_age + 1 >= total_len(m_eff)) begin
                    m_busy <= 1'b0; m_eff <= 0; m_age <= 0;
                end else begin
                    m_age <= m_age + 1;
                end
            end
            m_prev  <= bus.trig;
            m_armed <= 1'b1;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int s, t, sl;
            locate(m_eff, m_age, s, t, sl);
            check("busy",       32'(bus.busy),       32'(m_busy));
            check("cur_effect", 32'(bus.cur_effect), 32'(m_eff));
            check("step_idx",   32'(bus.step_idx),   m_busy ? 32'(s) : 32'd0);
            check("buzzer",     32'(bus.buzzer),     32'(m_buz));
        end
    end

    // Starts at a negedge: raise trig, clear it one cycle later. Returns at
    // the negedge right after the start edge.
    task automatic pulse(input logic [N-1:0] v);
        bus.trig = v;
        @(negedge clk);
        bus.trig = '0;
    endtask

    task automatic observe(input int n, input int inj_i, input logic [N-1:0] inj_v,
                           input int probe, output int nb, output int nh,
                           output int first, output int p_step, output int p_cur,
                           output int max_step);
        nb = 0; nh = 0; first = -1; p_step = -1; p_cur = -1; max_step = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.busy) nb++;
            if (bus.buzzer) begin
                nh++;
                if (first < 0) first = i;
            end
            if (int'(bus.step_idx) > max_step) max_step = int'(bus.step_idx);
            if (i == probe) begin
                p_step = int'(bus.step_idx);
                p_cur  = int'(bus.cur_effect);
            end
            if (i == inj_i) bus.trig = inj_v;
            else if (i == inj_i + 1) bus.trig = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb, nh, first, ps, pc, mx;
        bus.trig = '0; bus.mute = 1'b0; rst = 1'b1; chk_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; chk_en = 1'b1;
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_buzzer", 32'(bus.buzzer), 0);
        check("rst_cur",    32'(bus.cur_effect), 0);
        check("rst_step",   32'(bus.step_idx), 0);
        @(negedge clk);

        // Scenario 1: E0 basic
        pulse(3'b001);
        observe(20, -5, '0, 0, nb, nh, first, ps, pc, mx);
        check("s1_busy_cycles", nb, 8);
        check("s1_buz_cycles", nh, 4);
        check("s1_first_high", first, 5);

        // Scenario 2: E1 with a silent rest
        pulse(3'b010);
        observe(30, -5, '0, 10, nb, nh, first, ps, pc, mx);
        check("s2_busy_cycles", nb, 24);
        check("s2_buz_cycles", nh, 9);
        check("s2_rest_step", ps, 1);
        check("s2_first_high", first, 3);

        // Scenario 3: preempt by trig[2], then ignored trig[0]
        bus.trig = 3'b010;
        @(negedge clk); bus.trig = '0;
        @(negedge clk);
        @(negedge clk);
        pulse(3'b100);
        observe(30, 5, 3'b001, 7, nb, nh, first, ps, pc, mx);
        check("s3_busy_cycles", nb, 18);
        check("s3_cur_after_low", pc, 2);

        // Scenario 4: simultaneous edges, then retrigger of E2
        pulse(3'b101);
        observe(40, 6, 3'b100, 1, nb, nh, first, ps, pc, mx);
        check("s4_cur", pc, 2);
        check("s4_busy_cycles", nb, 25);

        // Scenario 5: mute during E1, then async reset mid-E2
        bus.mute = 1'b1;
        pulse(3'b010);
        observe(30, -5, '0, -1, nb, nh, first, ps, pc, mx);
        check("s5_mute_buz", nh, 0);
        check("s5_mute_steps", mx, 2);
        bus.mute = 1'b0;
        bus.trig = 3'b100;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        check("s5_busy_pre_rst", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("s5_async_busy",   32'(bus.busy), 0);
        check("s5_async_buzzer", 32'(bus.buzzer), 0);
        check("s5_async_cur",    32'(bus.cur_effect), 0);
        check("s5_async_step",   32'(bus.step_idx), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        observe(10, -5, '0, -1, nb, nh, first, ps, pc, mx);
        check("s5_no_start_after_rst", nb, 0);
        bus.trig = '0;
        repeat (2) @(negedge clk);

        // Random phase against the model
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            v = bus.trig;
            for (int b = 0; b < N; b++)
                if ($urandom_range(15) == 0) v[b] = ~v[b];
            bus.trig = v;
            if ($urandom_range(31) == 0) bus.mute = ~bus.mute;
            @(negedge clk);
        end
        bus.trig = '0; bus.mute = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
